// File: rtl/bpm_tick_duration_gen.sv
`timescale 1ns/1ps
// Tempo-to-tick phase accumulator plus a registered note-duration lookup.
// Optional BEAT output (one pulse per TICKS_PER_BEAT ticks) under `BPM_BEAT_PULSE_EN.
module bpm_tick_duration_gen #(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned TICKS_PER_BEAT = 512
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  BPM,
    input  logic [3:0]  NOTE,
    output logic        TICK,
    output logic [15:0] DURATION
`ifdef BPM_BEAT_PULSE_EN
    ,
    output logic        BEAT
`endif
);

    // Accumulator wraps at cycles-per-minute / ticks-per-beat, so BPM/THRESHOLD ticks per cycle.
    localparam longint unsigned THRESHOLD =
        (64'(CLK_HZ) * 64'd60) / 64'(TICKS_PER_BEAT);
    localparam int ACC_W = ($clog2(THRESHOLD) > 24) ? $clog2(THRESHOLD) : 24;
    localparam int SUM_W = ACC_W + 1;
    localparam logic [SUM_W-1:0] THR = SUM_W'(THRESHOLD);

    localparam int unsigned TPB = TICKS_PER_BEAT;
    localparam logic [15:0] D_SEMIBREVE      = 16'(TPB * 4);
    localparam logic [15:0] D_DOT_MINIM      = 16'(TPB * 3);
    localparam logic [15:0] D_MINIM          = 16'(TPB * 2);
    localparam logic [15:0] D_DOT_CROTCHET   = 16'((TPB * 3) / 2);
    localparam logic [15:0] D_CROTCHET       = 16'(TPB);
    localparam logic [15:0] D_DOT_QUAVER     = 16'((TPB * 3) / 4);
    localparam logic [15:0] D_QUAVER         = 16'(TPB / 2);
    localparam logic [15:0] D_DOT_SEMIQUAVER = 16'((TPB * 3) / 8);
    localparam logic [15:0] D_SEMIQUAVER     = 16'(TPB / 4);
    localparam logic [15:0] D_DEMISEMIQUAVER = 16'(TPB / 8);
    localparam logic [15:0] D_BREVE          = 16'(TPB * 8);
    localparam logic [15:0] D_QUAVER_TRIPLET = 16'(TPB / 3);

    typedef enum logic [3:0] {
        N_SEMIBREVE      = 4'd0,
        N_DOT_MINIM      = 4'd1,
        N_MINIM          = 4'd2,
        N_DOT_CROTCHET   = 4'd3,
        N_CROTCHET       = 4'd4,
        N_DOT_QUAVER     = 4'd5,
        N_QUAVER         = 4'd6,
        N_DOT_SEMIQUAVER = 4'd7,
        N_SEMIQUAVER     = 4'd8,
        N_DEMISEMIQUAVER = 4'd9,
        N_BREVE          = 4'd10,
        N_QUAVER_TRIPLET = 4'd11
    } note_e;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             tick_q, tick_d;
    logic [15:0]      dur_q, dur_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        sum    = SUM_W'(acc_q) + SUM_W'(BPM);
        acc_d  = sum[ACC_W-1:0];
        tick_d = 1'b0;
        if (sum >= THR) begin
            acc_d  = ACC_W'(sum - THR);
            tick_d = 1'b1;
        end
    end

    always_comb begin
        dur_d = D_CROTCHET;
        case (note_e'(NOTE))
            N_SEMIBREVE:      dur_d = D_SEMIBREVE;
            N_DOT_MINIM:      dur_d = D_DOT_MINIM;
            N_MINIM:          dur_d = D_MINIM;
            N_DOT_CROTCHET:   dur_d = D_DOT_CROTCHET;
            N_CROTCHET:       dur_d = D_CROTCHET;
            N_DOT_QUAVER:     dur_d = D_DOT_QUAVER;
            N_QUAVER:         dur_d = D_QUAVER;
            N_DOT_SEMIQUAVER: dur_d = D_DOT_SEMIQUAVER;
            N_SEMIQUAVER:     dur_d = D_SEMIQUAVER;
            N_DEMISEMIQUAVER: dur_d = D_DEMISEMIQUAVER;
            N_BREVE:          dur_d = D_BREVE;
            N_QUAVER_TRIPLET: dur_d = D_QUAVER_TRIPLET;
            default:          dur_d = D_CROTCHET;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
            dur_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
            dur_q  <= dur_d;
        end
    end

    assign TICK     = tick_q;
    assign DURATION = dur_q;

`ifdef BPM_BEAT_PULSE_EN
    localparam int BEAT_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(TICKS_PER_BEAT - 1);

    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              beat_q, beat_d;

    // The counter advances with the tick being issued, so BEAT lands on the wrapping TICK.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        beat_d     = 1'b0;
        if (tick_d) begin
            if (beat_cnt_q == BEAT_LAST) begin
                beat_cnt_d = '0;
                beat_d     = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            beat_cnt_q <= '0;
            beat_q     <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            beat_q     <= beat_d;
        end
    end

    assign BEAT = beat_q;
`endif

endmodule

// File: tb/tb_bpm_tick_duration_gen.sv
`timescale 1ns/1ps
// Self-checking bench: three instances (full-rate default plus two fast-threshold builds)
// checked every cycle against a cumulative-phase reference model.
module tb_bpm_tick_duration_gen;

    localparam longint unsigned THR_DEF = 64'd11718750;
    localparam longint unsigned THR_FST = 64'd3000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bpm;
    logic [3:0] note;

    logic        def_tick, s512_tick, s96_tick;
    logic [15:0] def_dur, s512_dur, s96_dur;
`ifdef BPM_BEAT_PULSE_EN
    logic        def_beat, s512_beat, s96_beat;
`endif

    always #5 clk = ~clk;

    bpm_tick_duration_gen dut_def (
        .CLK(clk), .RST_N(rst_n), .BPM(bpm), .NOTE(note),
        .TICK(def_tick), .DURATION(def_dur)
`ifdef BPM_BEAT_PULSE_EN
        , .BEAT(def_beat)
`endif
    );

    bpm_tick_duration_gen #(.CLK_HZ(25600), .TICKS_PER_BEAT(512)) dut_s512 (
        .CLK(clk), .RST_N(rst_n), .BPM(bpm), .NOTE(note),
        .TICK(s512_tick), .DURATION(s512_dur)
`ifdef BPM_BEAT_PULSE_EN
        , .BEAT(s512_beat)
`endif
    );

    bpm_tick_duration_gen #(.CLK_HZ(4800), .TICKS_PER_BEAT(96)) dut_s96 (
        .CLK(clk), .RST_N(rst_n), .BPM(bpm), .NOTE(note),
        .TICK(s96_tick), .DURATION(s96_dur)
`ifdef BPM_BEAT_PULSE_EN
        , .BEAT(s96_beat)
`endif
    );

    function automatic logic [15:0] dur512(input logic [3:0] n);
        case (n)
            4'd0: return 16'd2048;  4'd1: return 16'd1536;  4'd2: return 16'd1024;
            4'd3: return 16'd768;   4'd4: return 16'd512;   4'd5: return 16'd384;
            4'd6: return 16'd256;   4'd7: return 16'd192;   4'd8: return 16'd128;
            4'd9: return 16'd64;    4'd10: return 16'd4096; 4'd11: return 16'd170;
            default: return 16'd512;
        endcase
    endfunction

    function automatic logic [15:0] dur96(input logic [3:0] n);
        case (n)
            4'd0: return 16'd384;   4'd1: return 16'd288;   4'd2: return 16'd192;
            4'd3: return 16'd144;   4'd4: return 16'd96;    4'd5: return 16'd72;
            4'd6: return 16'd48;    4'd7: return 16'd36;    4'd8: return 16'd24;
            4'd9: return 16'd12;    4'd10: return 16'd768;  4'd11: return 16'd32;
            default: return 16'd96;
        endcase
    endfunction

    // Reference: total phase = sum of BPM over edges since reset; a tick is a change of phase/THRESHOLD.
    longint unsigned phase, nph;
    logic            m_def_tick, m_fst_tick;
    logic [15:0]     m_dur512, m_dur96;
`ifdef BPM_BEAT_PULSE_EN
    logic            m_def_beat, m_s512_beat, m_s96_beat;
`endif

    always @(posedge clk) begin
        if (!rst_n) begin
            phase      <= 0;
            m_def_tick <= 1'b0;
            m_fst_tick <= 1'b0;
            m_dur512   <= 16'd0;
            m_dur96    <= 16'd0;
`ifdef BPM_BEAT_PULSE_EN
            m_def_beat  <= 1'b0;
            m_s512_beat <= 1'b0;
            m_s96_beat  <= 1'b0;
`endif
        end else begin
            nph = phase + 64'(bpm);
            m_def_tick <= (nph / THR_DEF) != (phase / THR_DEF);
            m_fst_tick <= (nph / THR_FST) != (phase / THR_FST);
            m_dur512   <= dur512(note);
            m_dur96    <= dur96(note);
`ifdef BPM_BEAT_PULSE_EN
            m_def_beat  <= ((nph / THR_DEF) != (phase / THR_DEF)) && ((nph / THR_DEF) % 512 == 0);
            m_s512_beat <= ((nph / THR_FST) != (phase / THR_FST)) && ((nph / THR_FST) % 512 == 0);
            m_s96_beat  <= ((nph / THR_FST) != (phase / THR_FST)) && ((nph / THR_FST) % 96 == 0);
`endif
            phase <= nph;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int rel_cyc  = 0;
    int first_def = 0;
    int n_s512   = 0;
    bit rand_note = 1'b0;
    logic prev_s512 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d after release)", tag, obs, exp, rel_cyc);
        end
    endtask

    // Advance n cycles; every cycle compares all outputs against the model at the falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst_n) rel_cyc++;
            else       rel_cyc = 0;
            chk("def_tick",  32'(def_tick),  32'(m_def_tick));
            chk("s512_tick", 32'(s512_tick), 32'(m_fst_tick));
            chk("s96_tick",  32'(s96_tick),  32'(m_fst_tick));
            chk("def_dur",   32'(def_dur),   32'(m_dur512));
            chk("s512_dur",  32'(s512_dur),  32'(m_dur512));
            chk("s96_dur",   32'(s96_dur),   32'(m_dur96));
            chk("tick_gap",  32'(s512_tick & prev_s512), 32'd0);
`ifdef BPM_BEAT_PULSE_EN
            chk("def_beat",  32'(def_beat),  32'(m_def_beat));
            chk("s512_beat", 32'(s512_beat), 32'(m_s512_beat));
            chk("s96_beat",  32'(s96_beat),  32'(m_s96_beat));
`endif
            prev_s512 = s512_tick;
            if (s512_tick) n_s512++;
            if (def_tick && first_def == 0) first_def = rel_cyc;
            if (rand_note) note = 4'($urandom_range(0, 15));
        end
    endtask

    // Cycles until the next fast-instance tick, or -1 if the bound runs out.
    task automatic wait_s512_tick(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            step(1);
            if (s512_tick) begin
                cyc = i;
                break;
            end
        end
    endtask

    int c;
    int cnt0;

    initial begin
        rst_n = 1'b0;
        bpm   = 8'd200;
        note  = 4'd4;
        step(5);
        chk("rst_def_dur", 32'(def_dur), 32'd0);
        chk("rst_def_tick", 32'(def_tick), 32'd0);

        rst_n = 1'b1;
        bpm   = 8'd255;
        step(1);
        chk("dur_after_release", 32'(def_dur), 32'd512);
        chk("dur96_after_release", 32'(s96_dur), 32'd96);

        rand_note = 1'b1;
        step(46000);
        rand_note = 1'b0;
        chk("def_first_tick_cycle", 32'(first_def), 32'd45956);
        chk("s512_tick_count", 32'(n_s512), 32'((64'd46001 * 64'd255) / THR_FST));

        bpm  = 8'd0;
        cnt0 = n_s512;
        step(2000);
        chk("paused_ticks", 32'(n_s512 - cnt0), 32'd0);

        // 46001*255 mod 3000 = 255 left in the accumulator, so 11 more cycles reach 3000.
        bpm = 8'd255;
        wait_s512_tick(100, c);
        chk("resume_keeps_phase", 32'(c), 32'd11);

        rand_note = 1'b1;
        repeat (200) begin
            bpm = 8'($urandom_range(0, 255));
            step(int'($urandom_range(1, 40)));
        end
        rand_note = 1'b0;

        for (int n = 0; n < 16; n++) begin
            note = 4'(n);
            step(1);
            chk("note_sweep_512", 32'(def_dur), 32'(dur512(4'(n))));
            chk("note_sweep_96",  32'(s96_dur), 32'(dur96(4'(n))));
        end

        bpm = 8'd60;
        step(37);
        rst_n = 1'b0;
        step(1);
        chk("mid_reset_tick", 32'(s512_tick), 32'd0);
        chk("mid_reset_dur",  32'(s512_dur),  32'd0);
        rst_n = 1'b1;
        wait_s512_tick(200, c);
        chk("post_reset_first_tick", 32'(c), 32'd50);
        step(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
